traffic_sensor_conditioner: RTL and testbench

Front-end stage that turns the two raw, noisy vehicle-detector inputs of street A and street B into the clean traffic-present flags `TA` and `TB` consumed directly by `traffic_light_controller`. Each street channel synchronises its detector, debounces it, stretches occupancy across short inter-vehicle gaps with a hold timer, and counts vehicle arrivals. It sits between the roadside loop detectors and the light controller, on the same `clk`/`rst` domain.

---
 rtl/traffic_sensor_conditioner_pkg.sv | 15 +
 rtl/traffic_sensor_conditioner_channel.sv | 111 +++++++++++
 rtl/traffic_sensor_conditioner.sv | 47 ++++
 tb/tb_traffic_sensor_conditioner.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/traffic_sensor_conditioner_pkg.sv
// Shared definitions for the vehicle-detector conditioning front end:
// occupancy FSM encoding and default timing parameters.
package traffic_sensor_conditioner_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StPresent = 2'd1,
    StHold    = 2'd2
  } occ_state_e;

  localparam int unsigned DefDebCycles  = 4;
  localparam int unsigned DefHoldCycles = 16;
  localparam int unsigned DefCntW       = 8;

endpackage

// File: rtl/traffic_sensor_conditioner_channel.sv
// One street channel: two-flop synchroniser, debouncer, occupancy FSM with
// gap-bridging hold timer, and a saturating arrival counter.
module traffic_sensor_conditioner_channel
  import traffic_sensor_conditioner_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = DefDebCycles,
  parameter int unsigned HOLD_CYCLES = DefHoldCycles,
  parameter int unsigned CNT_W       = DefCntW
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             sense_i,
  input  logic             cnt_clr_i,
  output logic             t_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned DCntW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int unsigned HCntW = $clog2(HOLD_CYCLES + 1);

  logic             s1_q, s_q;
  logic             deb_q, deb_d;
  logic [DCntW-1:0] dcnt_q, dcnt_d;
  logic [HCntW-1:0] hcnt_q, hcnt_d;
  occ_state_e       state_q, state_d;
  logic             t_q, t_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             arrive;

  // A reversal before the threshold restarts the count.
  always_comb begin
    deb_d  = deb_q;
    dcnt_d = dcnt_q;
    if (s_q == deb_q) begin
      dcnt_d = '0;
    end else if (dcnt_q == DCntW'(DEB_CYCLES - 1)) begin
      deb_d  = s_q;
      dcnt_d = '0;
    end else begin
      dcnt_d = dcnt_q + DCntW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    arrive  = 1'b0;
    case (state_q)
      StIdle: begin
        if (deb_q) begin
          state_d = StPresent;
          arrive  = 1'b1;
        end
      end
      StPresent: begin
        if (!deb_q) begin
          state_d = StHold;
          hcnt_d  = HCntW'(HOLD_CYCLES - 1);
        end
      end
      StHold: begin
        if (deb_q) begin
          state_d = StPresent;
          arrive  = 1'b1;
        end else if (hcnt_q == '0) begin
          state_d = StIdle;
        end else begin
          hcnt_d = hcnt_q - HCntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    t_d = (state_d == StPresent) || (state_d == StHold);
  end

  // Clear takes priority over a coincident arrival.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr_i) begin
      cnt_d = '0;
    end else if (arrive && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q    <= 1'b0;
      s_q     <= 1'b0;
      deb_q   <= 1'b0;
      dcnt_q  <= '0;
      hcnt_q  <= '0;
      state_q <= StIdle;
      t_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= sense_i;
      s_q     <= s1_q;
      deb_q   <= deb_d;
      dcnt_q  <= dcnt_d;
      hcnt_q  <= hcnt_d;
      state_q <= state_d;
      t_q     <= t_d;
      cnt_q   <= cnt_d;
    end
  end

  assign t_o     = t_q;
  assign count_o = cnt_q;

endmodule

// File: rtl/traffic_sensor_conditioner.sv
// Two independent detector channels producing the TA/TB traffic-present flags
// and arrival counts for the light controller.
module traffic_sensor_conditioner
  import traffic_sensor_conditioner_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = DefDebCycles,
  parameter int unsigned HOLD_CYCLES = DefHoldCycles,
  parameter int unsigned CNT_W       = DefCntW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sense_a,
  input  logic             sense_b,
  input  logic             cnt_clr,
  output logic             TA,
  output logic             TB,
  output logic [CNT_W-1:0] count_a,
  output logic [CNT_W-1:0] count_b
);

  traffic_sensor_conditioner_channel #(
    .DEB_CYCLES (DEB_CYCLES),
    .HOLD_CYCLES(HOLD_CYCLES),
    .CNT_W      (CNT_W)
  ) u_chan_a (
    .clk_i    (clk),
    .rst_i    (rst),
    .sense_i  (sense_a),
    .cnt_clr_i(cnt_clr),
    .t_o      (TA),
    .count_o  (count_a)
  );

  traffic_sensor_conditioner_channel #(
    .DEB_CYCLES (DEB_CYCLES),
    .HOLD_CYCLES(HOLD_CYCLES),
    .CNT_W      (CNT_W)
  ) u_chan_b (
    .clk_i    (clk),
    .rst_i    (rst),
    .sense_i  (sense_b),
    .cnt_clr_i(cnt_clr),
    .t_o      (TB),
    .count_o  (count_b)
  );

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Directed and randomised bench for traffic_sensor_conditioner, checked every
// cycle against a window-based model of debounce, hold and arrival counting.
module tb_traffic_sensor_conditioner;

  localparam int unsigned Deb  = 4;
  localparam int unsigned Hold = 16;
  localparam int unsigned CntW = 8;
  localparam int CntMax = (1 << CntW) - 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            sense_a = 1'b0;
  logic            sense_b = 1'b0;
  logic            cnt_clr = 1'b0;
  logic            TA, TB;
  logic [CntW-1:0] count_a, count_b;

  int vectors = 0;
  int miscompares = 0;

  // Model state per channel: raw-sample delay line, window of synchronised
  // samples, debounced level, and the debounced levels seen at the last
  // Hold+1 edges (T is high while any of them is high).
  logic [1:0]     dly   [2];
  logic [Deb-1:0] win   [2];
  logic           deb_m [2];
  logic [Hold:0]  dh    [2];
  int             cnt_m [2];
  logic           t_m   [2];

  traffic_sensor_conditioner #(
    .DEB_CYCLES (Deb),
    .HOLD_CYCLES(Hold),
    .CNT_W      (CntW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .sense_a(sense_a),
    .sense_b(sense_b),
    .cnt_clr(cnt_clr),
    .TA     (TA),
    .TB     (TB),
    .count_a(count_a),
    .count_b(count_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input int c, input logic sense, input logic clr, input logic r);
    logic y;
    if (r) begin
      dly[c]   = '0;
      win[c]   = '0;
      deb_m[c] = 1'b0;
      dh[c]    = '0;
      cnt_m[c] = 0;
      t_m[c]   = 1'b0;
    end else begin
      y      = dly[c][1];
      dly[c] = {dly[c][0], sense};
      dh[c]  = {dh[c][Hold-1:0], deb_m[c]};
      t_m[c] = |dh[c];
      if (dh[c][0] && !dh[c][1] && cnt_m[c] < CntMax) cnt_m[c]++;
      if (clr) cnt_m[c] = 0;
      win[c] = {win[c][Deb-2:0], y};
      if (win[c] == {Deb{~deb_m[c]}}) deb_m[c] = ~deb_m[c];
    end
  endtask

  task automatic step(input logic a, input logic b, input logic clr, input logic r);
    sense_a = a;
    sense_b = b;
    cnt_clr = clr;
    rst     = r;
    @(posedge clk);
    model(0, a, clr, r);
    model(1, b, clr, r);
    #1;
    chk("TA", {31'b0, TA}, {31'b0, t_m[0]});
    chk("TB", {31'b0, TB}, {31'b0, t_m[1]});
    chk("count_a", {24'b0, count_a}, cnt_m[0]);
    chk("count_b", {24'b0, count_b}, cnt_m[1]);
  endtask

  task automatic reset3(input logic a, input logic b);
    for (int i = 0; i < 3; i++) begin
      step(a, b, 1'b0, 1'b1);
      chk("rst_ta", {31'b0, TA}, 32'd0);
      chk("rst_count_a", {24'b0, count_a}, 32'd0);
    end
  endtask

  initial begin
    int la, lb;
    logic va, vb, clr, r;

    // Reset with both detectors active, then exact rise latency.
    reset3(1'b1, 1'b1);
    for (int i = 0; i <= 6; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      chk("ta_latency", {31'b0, TA}, (i == 6) ? 32'd1 : 32'd0);
    end

    // Glitch rejection, then a minimal accepted pulse.
    reset3(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("glitch_count_a", {24'b0, count_a}, 32'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("pulse_count_a", {24'b0, count_a}, 32'd1);
    chk("pulse_ta", {31'b0, TA}, 32'd1);

    // Gap bridging on B, then a long gap that drops TB.
    reset3(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("bridge_count_b", {24'b0, count_b}, 32'd2);
    for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("drop_tb", {31'b0, TB}, 32'd0);
    chk("only_a_untouched", {24'b0, count_a}, 32'd0);

    // Saturation on A, then a clear coinciding with an arrival.
    reset3(1'b0, 1'b0);
    for (int n = 0; n < 260; n++) begin
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    end
    chk("sat_count_a", {24'b0, count_a}, 32'd255);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("clr_wins", {24'b0, count_a}, 32'd0);
    chk("clr_ta", {31'b0, TA}, 32'd1);

    // Identical random edges on both channels.
    va = 1'b0;
    la = 0;
    for (int k = 0; k < 400; k++) begin
      if (la == 0) begin
        va = ~va;
        la = $urandom_range(1, 24);
      end
      step(va, va, 1'b0, 1'b0);
      la--;
    end

    // Independent random runs with occasional clears and resets.
    vb = 1'b0;
    lb = 0;
    la = 0;
    for (int k = 0; k < 2500; k++) begin
      if (la == 0) begin
        va = ~va;
        la = $urandom_range(1, 24);
      end
      if (lb == 0) begin
        vb = ~vb;
        lb = $urandom_range(1, 24);
      end
      clr = ($urandom_range(0, 63) == 0);
      r   = ($urandom_range(0, 399) == 0);
      step(va, vb, clr, r);
      la--;
      lb--;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
